// File: rtl/sine_voice_scheduler_pkg.sv
// Shared types, default widths and helpers for the sine voice scheduler.
package sine_voice_scheduler_pkg;

  // Scheduler round states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  localparam int DEF_NUM_VOICES  = 4;
  localparam int DEF_ROM_LATENCY = 1;
  localparam int DEF_PHASE_W     = 32;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;

  // Ceiling log2, minimum 1 so single-bit indices stay legal
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sine_voice_regs.sv
// Per-voice tuning word, enable and phase accumulator, with a config write
// port and one scheduler-indexed read/advance port.
module sine_voice_regs
  import sine_voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int VID_W      = clog2(DEF_NUM_VOICES)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_we,
  input  logic [VID_W-1:0]   i_cfg_voice,
  input  logic [PHASE_W-1:0] i_cfg_inc,
  input  logic               i_cfg_en,
  input  logic [VID_W-1:0]   i_rd_idx,
  input  logic               i_adv,
  output logic [ADDR_W-1:0]  o_rd_addr,
  output logic               o_rd_en
);

  logic [ADDR_W-1:0]     addr_vec [NUM_VOICES];
  logic [NUM_VOICES-1:0] en_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic [PHASE_W-1:0] inc_reg;
      logic [PHASE_W-1:0] phase_reg;
      logic               en_reg;
      logic               cfg_hit;
      logic               adv_hit;

      assign cfg_hit = i_cfg_we && (i_cfg_voice == VID_W'(gi));
      // Advance only when enabled, so it never collides with the enable-time phase clear
      assign adv_hit = i_adv && (i_rd_idx == VID_W'(gi)) && en_reg;

      // Config write and post-increment phase advance for this voice
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          inc_reg   <= '0;
          phase_reg <= '0;
          en_reg    <= 1'b0;
        end else begin
          if (cfg_hit) begin
            inc_reg <= i_cfg_inc;
            en_reg  <= i_cfg_en;
            // Turning a voice on restarts it at phase 0; retuning a running voice keeps phase
            if (i_cfg_en && !en_reg) begin
              phase_reg <= '0;
            end
          end
          if (adv_hit) begin
            phase_reg <= phase_reg + inc_reg;
          end
        end
      end

      assign addr_vec[gi] = phase_reg[PHASE_W-1 -: ADDR_W];
      assign en_vec[gi]   = en_reg;
    end
  endgenerate

  // Pre-write values are presented, so a write landing in a voice's slot affects the next round
  assign o_rd_addr = addr_vec[i_rd_idx];
  assign o_rd_en   = en_vec[i_rd_idx];

endmodule

// File: rtl/sine_voice_scheduler.sv
// Time-multiplexes one sine ROM across NUM_VOICES NCO voices: one round per
// sample tick, per-voice samples tagged with a voice id, plus a per-round mix.
module sine_voice_scheduler
  import sine_voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES  = DEF_NUM_VOICES,
  parameter int ROM_LATENCY = DEF_ROM_LATENCY,
  parameter int PHASE_W     = DEF_PHASE_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int VID_W       = clog2(NUM_VOICES),
  parameter int MIX_W       = DATA_W + VID_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sample_tick,
  input  logic               i_cfg_we,
  input  logic [VID_W-1:0]   i_cfg_voice,
  input  logic [PHASE_W-1:0] i_cfg_inc,
  input  logic               i_cfg_en,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [DATA_W-1:0]  i_rom_data,
  output logic [DATA_W-1:0]  o_data,
  output logic [VID_W-1:0]   o_voice,
  output logic               o_valid,
  output logic [MIX_W-1:0]   o_mix,
  output logic               o_mix_valid,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int DRAIN_W = clog2(ROM_LATENCY + 2);

  sched_state_t       state_reg, state_next;
  logic [VID_W-1:0]   idx_reg, idx_next;
  logic [DRAIN_W-1:0] drain_reg, drain_next;
  logic               issue;
  logic               accept;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_en;

  logic [ADDR_W-1:0]    addr_reg;
  logic [VID_W-1:0]     pipe_vid_reg [ROM_LATENCY+1];
  logic [ROM_LATENCY:0] pipe_vld_reg;
  logic [DATA_W-1:0]    data_reg;
  logic [VID_W-1:0]     voice_reg;
  logic                 valid_reg;
  logic [MIX_W-1:0]     acc_reg;
  logic [MIX_W-1:0]     mix_reg;
  logic                 mix_valid_reg;
  logic                 busy_reg;
  logic                 overrun_reg;

  // A tick starts a round only when fully idle, including the cycle where busy is still showing
  assign accept = i_sample_tick && (state_reg == ST_IDLE) && !busy_reg;

  sine_voice_regs #(
    .NUM_VOICES(NUM_VOICES),
    .PHASE_W   (PHASE_W),
    .ADDR_W    (ADDR_W),
    .VID_W     (VID_W)
  ) u_regs (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_voice(i_cfg_voice),
    .i_cfg_inc  (i_cfg_inc),
    .i_cfg_en   (i_cfg_en),
    .i_rd_idx   (idx_reg),
    .i_adv      (issue),
    .o_rd_addr  (rd_addr),
    .o_rd_en    (rd_en)
  );

  // FSM state, voice index and drain counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      drain_reg <= drain_next;
    end
  end

  // Round sequencing: one issue slot per voice, then wait out the ROM and pipe
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    drain_next = drain_reg;
    issue      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_ISSUE;
          idx_next   = '0;
        end
      end
      ST_ISSUE: begin
        issue = 1'b1;
        if (idx_reg == VID_W'(NUM_VOICES - 1)) begin
          state_next = ST_DRAIN;
          drain_next = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_reg == DRAIN_W'(ROM_LATENCY)) begin
          state_next = ST_DONE;
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ROM address plus the voice id / valid pipe that tracks the ROM read latency
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_reg     <= '0;
      pipe_vld_reg <= '0;
      for (int i = 0; i <= ROM_LATENCY; i++) begin
        pipe_vid_reg[i] <= '0;
      end
    end else begin
      // Disabled voices keep the previous address; their slot is marked invalid
      if (issue && rd_en) begin
        addr_reg <= rd_addr;
      end
      pipe_vld_reg[0] <= issue && rd_en;
      pipe_vid_reg[0] <= idx_reg;
      for (int i = 1; i <= ROM_LATENCY; i++) begin
        pipe_vld_reg[i] <= pipe_vld_reg[i-1];
        pipe_vid_reg[i] <= pipe_vid_reg[i-1];
      end
    end
  end

  // Per-voice sample capture and round mix accumulation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_reg      <= '0;
      voice_reg     <= '0;
      valid_reg     <= 1'b0;
      acc_reg       <= '0;
      mix_reg       <= '0;
      mix_valid_reg <= 1'b0;
    end else begin
      valid_reg <= pipe_vld_reg[ROM_LATENCY];
      if (pipe_vld_reg[ROM_LATENCY]) begin
        data_reg  <= i_rom_data;
        voice_reg <= pipe_vid_reg[ROM_LATENCY];
      end
      // MIX_W leaves room for NUM_VOICES full-scale samples, so no saturation is needed
      if (accept) begin
        acc_reg <= '0;
      end else if (pipe_vld_reg[ROM_LATENCY]) begin
        acc_reg <= acc_reg + MIX_W'($signed(i_rom_data));
      end
      mix_valid_reg <= (state_reg == ST_DONE);
      if (state_reg == ST_DONE) begin
        mix_reg <= acc_reg;
      end
    end
  end

  // Busy status and dropped-tick flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      busy_reg    <= (state_reg != ST_IDLE);
      overrun_reg <= i_sample_tick && !accept;
    end
  end

  assign o_rom_addr  = addr_reg;
  assign o_data      = data_reg;
  assign o_voice     = voice_reg;
  assign o_valid     = valid_reg;
  assign o_mix       = mix_reg;
  assign o_mix_valid = mix_valid_reg;
  assign o_busy      = busy_reg;
  assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Directed bench for sine_voice_scheduler (4 voices, ROM latency 1) with a
// registered sine ROM model.
module tb_sine_voice_scheduler;

  logic        i_clk;
  logic        i_rst;
  logic        i_sample_tick;
  logic        i_cfg_we;
  logic [1:0]  i_cfg_voice;
  logic [31:0] i_cfg_inc;
  logic        i_cfg_en;
  logic [15:0] o_rom_addr;
  logic [15:0] i_rom_data;
  logic [15:0] o_data;
  logic [1:0]  o_voice;
  logic        o_valid;
  logic [17:0] o_mix;
  logic        o_mix_valid;
  logic        o_busy;
  logic        o_overrun;

  logic        rom_force;
  int          tests_run;
  int          tests_failed;

  // Per-edge capture of one round: index e means "just after edge T+e"
  logic [15:0] addr_at      [0:10];
  logic [15:0] data_at      [0:10];
  logic [1:0]  voice_at     [0:10];
  logic        valid_at     [0:10];
  logic [17:0] mix_at       [0:10];
  logic        mix_valid_at [0:10];
  logic        busy_at      [0:10];
  logic        overrun_at   [0:10];
  int          valid_cnt;
  int          mix_valid_cnt;
  int          overrun_cnt;

  sine_voice_scheduler dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_sample_tick(i_sample_tick),
    .i_cfg_we     (i_cfg_we),
    .i_cfg_voice  (i_cfg_voice),
    .i_cfg_inc    (i_cfg_inc),
    .i_cfg_en     (i_cfg_en),
    .o_rom_addr   (o_rom_addr),
    .i_rom_data   (i_rom_data),
    .o_data       (o_data),
    .o_voice      (o_voice),
    .o_valid      (o_valid),
    .o_mix        (o_mix),
    .o_mix_valid  (o_mix_valid),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] sine_lookup(input logic [15:0] a);
    real x;
    x = 32767.0 * $sin(6.283185307179586 * real'(a) / 65536.0);
    return 16'($rtoi(x + ((x >= 0.0) ? 0.5 : -0.5)));
  endfunction

  // Sine ROM: one cycle from registered address to data
  always @(posedge i_clk) begin
    i_rom_data <= rom_force ? 16'h7FFF : sine_lookup(o_rom_addr);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] v, input logic [31:0] inc, input logic en);
    i_cfg_voice = v;
    i_cfg_inc   = inc;
    i_cfg_en    = en;
    i_cfg_we    = 1'b1;
    step();
    i_cfg_we    = 1'b0;
  endtask

  // Tick sampled at edge T; optional extra tick / config strobe / reset sampled at edge T+n
  task automatic run_round(input int tick2_at, input int cfg_at, input int rst_at);
    valid_cnt     = 0;
    mix_valid_cnt = 0;
    overrun_cnt   = 0;
    i_sample_tick = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      step();
      i_sample_tick   = (e + 1 == tick2_at);
      i_cfg_we        = (e + 1 == cfg_at);
      i_rst           = (e + 1 == rst_at);
      addr_at[e]      = o_rom_addr;
      data_at[e]      = o_data;
      voice_at[e]     = o_voice;
      valid_at[e]     = o_valid;
      mix_at[e]       = o_mix;
      mix_valid_at[e] = o_mix_valid;
      busy_at[e]      = o_busy;
      overrun_at[e]   = o_overrun;
      if (o_valid) valid_cnt++;
      if (o_mix_valid) mix_valid_cnt++;
      if (o_overrun) overrun_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_v0_addr [3];
    logic [15:0] exp_v0_data [3];
    logic [15:0] exp_v1_addr [3];
    logic [17:0] exp_mix3    [3];

    tests_run     = 0;
    tests_failed  = 0;
    rom_force     = 1'b0;
    i_rst         = 1'b1;
    i_sample_tick = 1'b0;
    i_cfg_we      = 1'b0;
    i_cfg_voice   = '0;
    i_cfg_inc     = '0;
    i_cfg_en      = 1'b0;
    repeat (3) step();
    i_rst = 1'b0;
    step();

    // Reset state
    check("rst_addr", 32'(o_rom_addr), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_mix_valid", 32'(o_mix_valid), 32'h0);
    check("rst_mix", 32'(o_mix), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_overrun", 32'(o_overrun), 32'h0);
    $display("[TB] reset state checked");

    // 1: no voices enabled
    run_round(-1, -1, -1);
    check("t1_busy_T0", 32'(busy_at[0]), 32'h0);
    check("t1_busy_T1", 32'(busy_at[1]), 32'h1);
    check("t1_busy_T7", 32'(busy_at[7]), 32'h1);
    check("t1_busy_T8", 32'(busy_at[8]), 32'h0);
    check("t1_valid_cnt", 32'(valid_cnt), 32'd0);
    check("t1_mixv_T6", 32'(mix_valid_at[6]), 32'h0);
    check("t1_mixv_T7", 32'(mix_valid_at[7]), 32'h1);
    check("t1_mixv_cnt", 32'(mix_valid_cnt), 32'd1);
    check("t1_mix", 32'(mix_at[7]), 32'h0);
    check("t1_overrun_cnt", 32'(overrun_cnt), 32'd0);
    $display("[TB] round 1 (no voices): mix=0x%0h", mix_at[7]);

    // 2: voice 0 steps one ROM address per round
    exp_v0_addr = '{16'h0000, 16'h0001, 16'h0002};
    exp_v0_data = '{16'd0, 16'd3, 16'd6};
    cfg_write(2'd0, 32'h0001_0000, 1'b1);
    for (int r = 0; r < 3; r++) begin
      run_round(-1, -1, -1);
      check($sformatf("t2_addr_r%0d", r), 32'(addr_at[1]), 32'(exp_v0_addr[r]));
      check($sformatf("t2_addr_hold_r%0d", r), 32'(addr_at[4]), 32'(exp_v0_addr[r]));
      check($sformatf("t2_valid_r%0d", r), 32'(valid_at[3]), 32'h1);
      check($sformatf("t2_voice_r%0d", r), 32'(voice_at[3]), 32'h0);
      check($sformatf("t2_data_r%0d", r), 32'(data_at[3]), 32'(exp_v0_data[r]));
      check($sformatf("t2_data_hold_r%0d", r), 32'(data_at[6]), 32'(exp_v0_data[r]));
      check($sformatf("t2_valid_cnt_r%0d", r), 32'(valid_cnt), 32'd1);
      check($sformatf("t2_mix_r%0d", r), 32'(mix_at[7]), 32'(exp_v0_data[r]));
      $display("[TB] round 2.%0d: addr=0x%0h data=0x%0h mix=0x%0h", r, addr_at[1], data_at[3], mix_at[7]);
    end

    // 3: voice 1 at half-cycle increment wraps between 0x0000 and 0x8000
    exp_v1_addr = '{16'h0000, 16'h8000, 16'h0000};
    exp_mix3    = '{18'd9, 18'd13, 18'd16};
    cfg_write(2'd1, 32'h8000_0000, 1'b1);
    for (int r = 0; r < 3; r++) begin
      run_round(-1, -1, -1);
      check($sformatf("t3_v0_addr_r%0d", r), 32'(addr_at[1]), 32'(16'(r + 3)));
      check($sformatf("t3_v1_addr_r%0d", r), 32'(addr_at[2]), 32'(exp_v1_addr[r]));
      check($sformatf("t3_v1_valid_r%0d", r), 32'(valid_at[4]), 32'h1);
      check($sformatf("t3_v1_voice_r%0d", r), 32'(voice_at[4]), 32'h1);
      check($sformatf("t3_v1_data_r%0d", r), 32'(data_at[4]), 32'h0);
      check($sformatf("t3_mix_r%0d", r), 32'(mix_at[7]), 32'(exp_mix3[r]));
      $display("[TB] round 3.%0d: v1 addr=0x%0h mix=0x%0h", r, addr_at[2], mix_at[7]);
    end

    // 4: second tick mid-round is dropped and flagged
    run_round(3, -1, -1);
    check("t4_overrun_T3", 32'(overrun_at[3]), 32'h1);
    check("t4_overrun_T4", 32'(overrun_at[4]), 32'h0);
    check("t4_overrun_cnt", 32'(overrun_cnt), 32'd1);
    check("t4_valid_cnt", 32'(valid_cnt), 32'd2);
    check("t4_mixv_cnt", 32'(mix_valid_cnt), 32'd1);
    check("t4_mix", 32'(mix_at[7]), 32'd19);
    check("t4_busy_T10", 32'(busy_at[10]), 32'h0);
    $display("[TB] round 4 (overrun): overruns=%0d valids=%0d", overrun_cnt, valid_cnt);

    // 5: retune voice 2 inside its own slot, then disable / re-enable
    cfg_write(2'd2, 32'h0100_0000, 1'b1);
    run_round(-1, -1, -1);
    check("t5_a_addr", 32'(addr_at[3]), 32'h0000);
    i_cfg_voice = 2'd2;
    i_cfg_inc   = 32'h0200_0000;
    i_cfg_en    = 1'b1;
    run_round(-1, 3, -1);
    check("t5_b_addr_old_phase", 32'(addr_at[3]), 32'h0100);
    run_round(-1, -1, -1);
    check("t5_c_addr_old_inc", 32'(addr_at[3]), 32'h0200);
    run_round(-1, -1, -1);
    check("t5_d_addr_new_inc", 32'(addr_at[3]), 32'h0400);
    cfg_write(2'd2, 32'h0200_0000, 1'b0);
    run_round(-1, -1, -1);
    check("t5_e_v2_valid", 32'(valid_at[5]), 32'h0);
    check("t5_e_valid_cnt", 32'(valid_cnt), 32'd2);
    check("t5_e_addr_held", 32'(addr_at[3]), 32'h0000);
    cfg_write(2'd2, 32'h0200_0000, 1'b1);
    run_round(-1, -1, -1);
    check("t5_f_v1_addr", 32'(addr_at[2]), 32'h8000);
    check("t5_f_v2_restart", 32'(addr_at[3]), 32'h0000);
    check("t5_f_v2_valid", 32'(valid_at[5]), 32'h1);
    check("t5_f_v2_voice", 32'(voice_at[5]), 32'h2);
    $display("[TB] round 5: voice2 restart addr=0x%0h", addr_at[3]);

    // 6: full-scale mix with all voices, then reset mid-round
    cfg_write(2'd3, 32'h0000_1000, 1'b1);
    rom_force = 1'b1;
    step();
    run_round(-1, -1, -1);
    check("t6_valid_cnt", 32'(valid_cnt), 32'd4);
    check("t6_v3_voice", 32'(voice_at[6]), 32'h3);
    check("t6_v3_data", 32'(data_at[6]), 32'h7FFF);
    check("t6_mix", 32'(mix_at[7]), 32'h1FFFC);
    $display("[TB] round 6: mix=0x%0h", mix_at[7]);
    run_round(-1, -1, 3);
    check("t6_rst_valid_cnt", 32'(valid_cnt), 32'd0);
    check("t6_rst_mixv_cnt", 32'(mix_valid_cnt), 32'd0);
    check("t6_rst_busy", 32'(busy_at[3]), 32'h0);
    check("t6_rst_addr", 32'(addr_at[3]), 32'h0000);
    check("t6_rst_busy_end", 32'(busy_at[10]), 32'h0);
    run_round(-1, -1, -1);
    check("t6_post_valid_cnt", 32'(valid_cnt), 32'd0);
    check("t6_post_mixv", 32'(mix_valid_at[7]), 32'h1);
    check("t6_post_mix", 32'(mix_at[7]), 32'h0);
    $display("[TB] round 6 reset: valids=%0d", valid_cnt);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
